ysyx_201979054_reg_wr_arbiter: RTL

- Shares the write port of one nonarchitectural write-enabled register among NUM_REQ requesters, e.g. the fetch, memory and CSR units.
- Uses round-robin arbitration with a per-requester lock, so one unit can issue back-to-back writes without being interleaved.
- Sits in front of the register_en instance and drives its write enable and write data directly.

---
 rtl/ysyx_201979054_reg_wr_arbiter_if.sv | 28 ++
 rtl/ysyx_201979054_reg_wr_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_201979054_reg_wr_arbiter_if.sv
// Write-port bundle between the requesters and the register write arbiter.
// The arbiter takes the slave side; the requesters (or a bench) take the master side.
interface ysyx_201979054_reg_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            i_req;
   logic [NUM_REQ-1:0]            i_lock;
   logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata;
   logic [NUM_REQ-1:0]            o_ack;
   logic                          o_write_en;
   logic [DATA_WIDTH-1:0]         o_write_data;
   logic [ID_W-1:0]               o_grant_id;
   logic                          o_busy;
   logic                          o_lock_timeout;

   modport slave (
      input  i_req, i_lock, i_wdata,
      output o_ack, o_write_en, o_write_data, o_grant_id, o_busy, o_lock_timeout
   );

   modport master (
      output i_req, i_lock, i_wdata,
      input  o_ack, o_write_en, o_write_data, o_grant_id, o_busy, o_lock_timeout
   );
endinterface

// File: rtl/ysyx_201979054_reg_wr_arbiter.sv
// Round-robin arbiter with per-owner lock sharing one register write port.
// Optional forced lock release after LOCK_MAX idle LOCKED cycles: define YSYX_201979054_LOCK_TIMEOUT_EN.
module ysyx_201979054_reg_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int LOCK_MAX   = 16
) (
   input logic clk,
   input logic arst,
   ysyx_201979054_reg_wr_arbiter_if.slave bus
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || LOCK_MAX < 1) begin : gBadParams
      $error("ysyx_201979054_reg_wr_arbiter: NUM_REQ must be >= 2 and LOCK_MAX >= 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t                  state_q;
   logic [ID_W-1:0]         rrPtr_q;
   logic [ID_W-1:0]         grantId_q;
   logic [NUM_REQ-1:0]      ack_q;
   logic                    writeEn_q;
   logic                    busy_q;
   logic [DATA_WIDTH-1:0]   wdata_q;

   logic                    winValid;
   logic [ID_W-1:0]         winId;
   logic [ID_W-1:0]         rrPtrNext;
   logic [NUM_REQ-1:0]      winOneHot;
   logic [DATA_WIDTH-1:0]   winData;
   logic [NUM_REQ-1:0]      ownerOneHot;
   logic [DATA_WIDTH-1:0]   ownerData;
   logic                    ownerReq;
   logic                    ownerLock;

   // First set request at or above the round-robin pointer, wrapping around.
   always_comb begin
      int idx;
      idx      = 0;
      winValid = 1'b0;
      winId    = rrPtr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rrPtr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!winValid && bus.i_req[ID_W'(idx)]) begin
            winValid = 1'b1;
            winId    = ID_W'(idx);
         end
      end
   end

   assign rrPtrNext = (int'(winId) == NUM_REQ - 1) ? '0 : winId + 1'b1;

   always_comb begin
      winOneHot   = '0;
      winData     = '0;
      ownerOneHot = '0;
      ownerData   = '0;
      ownerReq    = 1'b0;
      ownerLock   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (ID_W'(k) == winId) begin
            winOneHot[k] = 1'b1;
            winData      = bus.i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
         end
         if (ID_W'(k) == grantId_q) begin
            ownerOneHot[k] = 1'b1;
            ownerData      = bus.i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            ownerReq       = bus.i_req[k];
            ownerLock      = bus.i_lock[k];
         end
      end
   end

`ifdef YSYX_201979054_LOCK_TIMEOUT_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   logic [CNT_W-1:0] lockCnt_q;
   logic             timeout_q;
`endif

   // Outputs are registered alongside the state, so ack/write_en appear in the WRITE cycle.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= IDLE;
         rrPtr_q   <= '0;
         grantId_q <= '0;
         ack_q     <= '0;
         writeEn_q <= 1'b0;
         busy_q    <= 1'b0;
         wdata_q   <= '0;
`ifdef YSYX_201979054_LOCK_TIMEOUT_EN
         lockCnt_q <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         ack_q     <= '0;
         writeEn_q <= 1'b0;
`ifdef YSYX_201979054_LOCK_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (winValid) begin
                  wdata_q   <= winData;
                  grantId_q <= winId;
                  rrPtr_q   <= rrPtrNext;
                  ack_q     <= winOneHot;
                  writeEn_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= WRITE;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            WRITE: begin
               if (ownerLock) begin
                  busy_q  <= 1'b1;
                  state_q <= LOCKED;
`ifdef YSYX_201979054_LOCK_TIMEOUT_EN
                  lockCnt_q <= '0;
`endif
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            LOCKED: begin
               if (ownerReq) begin
                  wdata_q   <= ownerData;
                  ack_q     <= ownerOneHot;
                  writeEn_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= WRITE;
               end else if (!ownerLock) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
`ifdef YSYX_201979054_LOCK_TIMEOUT_EN
               // Owner sat on the lock too long: release it back to round-robin.
               else if (lockCnt_q == CNT_W'(LOCK_MAX - 1)) begin
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  lockCnt_q <= lockCnt_q + 1'b1;
               end
`endif
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_ack        = ack_q;
   assign bus.o_write_en   = writeEn_q;
   assign bus.o_write_data = wdata_q;
   assign bus.o_grant_id   = grantId_q;
   assign bus.o_busy       = busy_q;
`ifdef YSYX_201979054_LOCK_TIMEOUT_EN
   assign bus.o_lock_timeout = timeout_q;
`else
   assign bus.o_lock_timeout = 1'b0;
`endif

endmodule
